// File: rtl/aes_req_arbiter.sv
// Round-robin sharing of one fully pipelined aes_128 core between NUM_REQ requesters.
// Ownership rides a delay line beside the core; credits keep every response FIFO from overflowing.
module aes_req_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned LATENCY   = 21,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_state,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic [127:0]           core_state,
    output logic [127:0]           core_key,
    input  logic [127:0]           core_out,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [NUM_REQ*128-1:0] resp_data,
    output logic                   busy
);
    localparam int unsigned TagW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);
    localparam int unsigned IdxW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(OUT_DEPTH);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(OUT_DEPTH - 1);
    localparam logic [TagW-1:0] LastTag  = TagW'(NUM_REQ - 1);

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] v);
        return (v == LastIdx) ? '0 : v + IdxW'(1);
    endfunction

    logic [TagW-1:0]    ptr_q;
    logic [CntW-1:0]    credit_q [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [TagW-1:0]    grant_idx;
    logic               issue;

    logic [LATENCY-1:0] dl_valid_q;
    logic [TagW-1:0]    dl_tag_q [LATENCY];

    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [127:0]       mem_q   [NUM_REQ][OUT_DEPTH];
    logic [IdxW-1:0]    wr_q    [NUM_REQ];
    logic [IdxW-1:0]    rd_q    [NUM_REQ];
    logic [CntW-1:0]    count_q [NUM_REQ];

    // ---------------- arbitration ----------------
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (credit_q[i] != '0);
        end
    end

    always_comb begin
        logic            found;
        int              idx;
        logic [TagW-1:0] cand;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = TagW'(idx);
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
        if (rst) begin
            grant     = '0;
            grant_idx = '0;
        end
    end

    assign req_ready = grant;
    assign issue     = |grant;

    // Idle cycles feed zeros so no stale plaintext or key enters the core.
    always_comb begin
        core_state = '0;
        core_key   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                core_state = req_state[128*i +: 128];
                core_key   = req_key[128*i +: 128];
            end
        end
    end

    // ---------------- ownership delay line ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid_q <= '0;
        end else begin
            dl_valid_q[0] <= issue;
            for (int s = 1; s < LATENCY; s++) begin
                dl_valid_q[s] <= dl_valid_q[s-1];
            end
        end
    end

    // Tags are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        dl_tag_q[0] <= grant_idx;
        for (int s = 1; s < LATENCY; s++) begin
            dl_tag_q[s] <= dl_tag_q[s-1];
        end
    end

    // ---------------- response FIFOs ----------------
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            push[i] = dl_valid_q[LATENCY-1] && (dl_tag_q[LATENCY-1] == TagW'(i));
            pop[i]  = resp_valid[i] && resp_ready[i];
        end
    end

    always_comb begin
        resp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (count_q[i] != '0);
            if (resp_valid[i]) begin
                resp_data[128*i +: 128] = mem_q[i][rd_q[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem_q[i][wr_q[i]] <= core_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_q[i]     <= '0;
                rd_q[i]     <= '0;
                count_q[i]  <= '0;
                credit_q[i] <= DepthCnt;
            end
        end else begin
            if (issue) begin
                ptr_q <= (grant_idx == LastTag) ? '0 : grant_idx + TagW'(1);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) begin
                    wr_q[i] <= next_idx(wr_q[i]);
                end
                if (pop[i]) begin
                    rd_q[i] <= next_idx(rd_q[i]);
                end
                if (push[i] && !pop[i]) begin
                    count_q[i] <= count_q[i] + CntW'(1);
                end else if (!push[i] && pop[i]) begin
                    count_q[i] <= count_q[i] - CntW'(1);
                end
                // A credit leaves with an issue and comes back when the requester pops.
                if (grant[i] && !pop[i]) begin
                    credit_q[i] <= credit_q[i] - CntW'(1);
                end else if (!grant[i] && pop[i]) begin
                    credit_q[i] <= credit_q[i] + CntW'(1);
                end
            end
        end
    end

    assign busy = (|dl_valid_q) || (|resp_valid);

    // ---------------- accounting checks ----------------
    int unsigned inflight [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            inflight[i] = 0;
            for (int s = 0; s < LATENCY; s++) begin
                if (dl_valid_q[s] && (dl_tag_q[s] == TagW'(i))) begin
                    inflight[i] = inflight[i] + 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                assert (!(push[i] && !pop[i] && (count_q[i] == DepthCnt)));
                assert (credit_q[i] <= DepthCnt);
                assert ((int'(credit_q[i]) + int'(inflight[i]) + int'(count_q[i])) == OUT_DEPTH);
            end
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: a stand-in pipelined core, directed stimulus and a
// per-requester scoreboard fed on issue and drained by a monitor on every pop.
module tb_aes_req_arbiter;
    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned LATENCY   = 21;
    localparam int unsigned OUT_DEPTH = 4;

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_S = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K0     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1     = 128'h8e73b0f7da0e6452c810f32b809079e5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_state;
    logic [NUM_REQ*128-1:0] req_key;
    logic [127:0]           core_state;
    logic [127:0]           core_key;
    logic [127:0]           core_out;
    logic [NUM_REQ-1:0]     resp_valid;
    logic [NUM_REQ-1:0]     resp_ready;
    logic [NUM_REQ*128-1:0] resp_data;
    logic                   busy;

    always #5 clk = ~clk;

    aes_req_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .LATENCY  (LATENCY),
        .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_state (req_state),
        .req_key   (req_key),
        .core_state(core_state),
        .core_key  (core_key),
        .core_out  (core_out),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .busy      (busy)
    );

    // Stand-in cipher: the FIPS-197 vector maps to its ciphertext, anything else to a keyed mix.
    function automatic logic [127:0] stub(input logic [127:0] s, input logic [127:0] k);
        if (s == FIPS_S && k == FIPS_K) return FIPS_C;
        return s ^ {k[63:0], k[127:64]};
    endfunction

    logic [127:0] pipe [LATENCY];
    always @(posedge clk) begin
        pipe[0] <= stub(core_state, core_key);
        for (int s = 1; s < LATENCY; s++) pipe[s] <= pipe[s-1];
    end
    assign core_out = pipe[LATENCY-1];

    int vectors     = 0;
    int miscompares = 0;
    logic [127:0] exp_q0[$];
    logic [127:0] exp_q1[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_n(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard monitor: pops compared before this cycle's issues are queued.
    always @(negedge clk) begin
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (resp_valid[0] && resp_ready[0]) begin
                check_n("resp0_expected", int'(exp_q0.size() != 0), 1);
                if (exp_q0.size() != 0) check("resp0_data", resp_data[127:0], exp_q0.pop_front());
            end
            if (resp_valid[1] && resp_ready[1]) begin
                check_n("resp1_expected", int'(exp_q1.size() != 0), 1);
                if (exp_q1.size() != 0) check("resp1_data", resp_data[255:128], exp_q1.pop_front());
            end
            if (req_valid[0] && req_ready[0]) exp_q0.push_back(stub(req_state[127:0], req_key[127:0]));
            if (req_valid[1] && req_ready[1]) exp_q1.push_back(stub(req_state[255:128], req_key[255:128]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    function automatic logic [127:0] st(input int i, input int c);
        return {8'(i), 24'h5a5a5a, 32'(c), 64'h0123_4567_89ab_cdef};
    endfunction

    task automatic drive(input int c);
        req_state = {st(1, c), st(0, c)};
        req_key   = {K1, K0};
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        step();
        req_valid  = '0;
        resp_ready = '1;
        probe();
        n = 0;
        while (n < 200 && (busy || exp_q0.size() != 0 || exp_q1.size() != 0)) begin
            step();
            probe();
            n++;
        end
        check_n({tag, "_drained"}, int'(busy) + exp_q0.size() + exp_q1.size(), 0);
    endtask

    task automatic fips_run(input string tag);
        step();
        req_valid  = 2'b01;
        resp_ready = 2'b11;
        req_state  = {st(1, 0), FIPS_S};
        req_key    = {K1, FIPS_K};
        probe();
        check_n({tag, "_grant"}, int'(req_ready), 1);
        for (int c = 1; c <= 21; c++) begin
            step();
            req_valid = '0;
            probe();
            check_n({tag, "_early_valid"}, int'(resp_valid), 0);
            check_n({tag, "_busy"}, int'(busy), 1);
        end
        step();
        probe();
        check_n({tag, "_valid"}, int'(resp_valid), 1);
        check({tag, "_data"}, resp_data[127:0], FIPS_C);
        step();
        probe();
        check_n({tag, "_valid_after_pop"}, int'(resp_valid), 0);
        check_n({tag, "_busy_after_pop"}, int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int g1;
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = '1;
        drive(0);

        // Reset state, with requests held valid during reset.
        probe();
        check_n("rst_req_ready", int'(req_ready), 0);
        check_n("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_data0", resp_data[127:0], 128'h0);
        check_n("rst_busy", int'(busy), 0);
        do_reset();

        // 1: FIPS-197 single request.
        fips_run("t1");

        // 2: contention, alternating grants until credits run out.
        do_reset();
        resp_ready = 2'b11;
        for (int c = 0; c < 8; c++) begin
            step();
            req_valid = 2'b11;
            drive(c);
            probe();
            check_n("t2_grant", int'(req_ready), (c % 2 == 0) ? 1 : 2);
        end
        step();
        drive(8);
        probe();
        check_n("t2_credit_stall", int'(req_ready), 0);
        drain("t2");

        // 3 and 4: requester 0 never pops, then single pops and issue-with-pop.
        do_reset();
        resp_ready = 2'b10;
        for (int c = 0; c < 8; c++) begin
            step();
            req_valid = 2'b11;
            drive(100 + c);
            probe();
            check_n("t3_grant", int'(req_ready), (c % 2 == 0) ? 1 : 2);
        end
        g0 = 0;
        g1 = 0;
        for (int c = 8; c <= 40; c++) begin
            step();
            drive(100 + c);
            probe();
            g0 += int'(req_ready[0]);
            g1 += int'(req_ready[1]);
        end
        check_n("t3_req0_stalled", g0, 0);
        check_n("t3_req1_grants", g1, 4);
        check_n("t3_fifo0_valid", int'(resp_valid[0]), 1);
        step();
        req_valid  = 2'b01;
        resp_ready = 2'b01;
        drive(141);
        probe();
        check_n("t3_no_credit", int'(req_ready), 0);
        step();
        resp_ready = 2'b00;
        drive(142);
        probe();
        check_n("t3_reassert", int'(req_ready), 1);
        step();
        resp_ready = 2'b01;
        drive(143);
        probe();
        check_n("t4_credit_zero", int'(req_ready), 0);
        step();
        drive(144);
        probe();
        check_n("t4_issue_and_pop", int'(req_ready), 1);
        step();
        resp_ready = 2'b00;
        drive(145);
        probe();
        check_n("t4_credit_kept", int'(req_ready), 1);
        step();
        drive(146);
        probe();
        check_n("t4_credit_spent", int'(req_ready), 0);
        drain("t3");

        // 5: reset while five requests are in flight.
        do_reset();
        resp_ready = 2'b11;
        for (int c = 0; c < 5; c++) begin
            step();
            req_valid = 2'b11;
            drive(200 + c);
            probe();
            check_n("t5_grant", int'(req_ready), (c % 2 == 0) ? 1 : 2);
        end
        step();
        req_valid = '0;
        for (int c = 6; c < 10; c++) step();
        step();
        rst = 1'b1;
        probe();
        step();
        rst = 1'b0;
        probe();
        check_n("t5_busy_after_rst", int'(busy), 0);
        for (int k = 0; k < 30; k++) begin
            step();
            probe();
            check_n("t5_no_resp", int'(resp_valid), 0);
        end
        fips_run("t5");
        g0 = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            req_valid  = 2'b01;
            resp_ready = 2'b00;
            drive(300 + c);
            probe();
            g0 += int'(req_ready[0]);
        end
        check_n("t5_credits", g0, 4);
        drain("t5");

        // 6: idle with nonzero data on the request buses.
        step();
        req_valid = '0;
        req_state = '1;
        req_key   = {8{32'hdeadbeef}};
        for (int c = 0; c < 50; c++) begin
            if (c > 0) step();
            probe();
            check("t6_core_state", core_state, 128'h0);
            check("t6_core_key", core_key, 128'h0);
            check_n("t6_resp_valid", int'(resp_valid), 0);
            check_n("t6_busy", int'(busy), 0);
        end

        check_n("end_q0_empty", exp_q0.size(), 0);
        check_n("end_q1_empty", exp_q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
